// File: rtl/multiply_divide_unit_pkg.sv
// rtl/multiply_divide_unit_pkg.sv - shared types for the multiply/divide unit
package multiply_divide_unit_pkg;

    typedef logic [31:0] vec32_t;
    typedef logic [63:0] vec64_t;

    typedef enum logic [3:0] {
        mduOp_none  = 4'd0,
        mduOp_mult  = 4'd1,
        mduOp_multu = 4'd2,
        mduOp_div   = 4'd3,
        mduOp_divu  = 4'd4,
        mduOp_mfhi  = 4'd5,
        mduOp_mflo  = 4'd6,
        mduOp_mthi  = 4'd7,
        mduOp_mtlo  = 4'd8
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_t;

    localparam int CNT_W = 6;

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - iterative restoring divider with sign fix-up (macro MDU_DIV_EARLY_OUT_EN)
module mdu_divider
    import multiply_divide_unit_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   load,
    input  logic   step,
    input  logic   is_signed,
    input  vec32_t dividend,
    input  vec32_t divisor,
    output logic   early,
    output vec32_t quotient,
    output vec32_t remainder
);

    vec32_t rem_q, rem_d;
    vec32_t quo_q, quo_d;
    vec32_t dsor_q, dsor_d;
    vec32_t dividend_q, dividend_d;
    logic   neg_quo_q, neg_quo_d;
    logic   neg_rem_q, neg_rem_d;
    logic   zero_q, zero_d;
    logic   early_q, early_d;

    vec32_t      mag_dividend;
    vec32_t      mag_divisor;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic        fits;
    vec32_t      rem_next;
    vec32_t      quo_next;

    assign mag_dividend = (is_signed && dividend[31]) ? (-dividend) : dividend;
    assign mag_divisor  = (is_signed && divisor[31])  ? (-divisor)  : divisor;

`ifdef MDU_DIV_EARLY_OUT_EN
    assign early = (divisor == 32'd0) || (mag_dividend < mag_divisor);
`else
    assign early = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift = {rem_q, quo_q[31]};
    assign diff      = rem_shift - {1'b0, dsor_q};
    assign fits      = ~diff[32];
    assign rem_next  = fits ? diff[31:0] : rem_shift[31:0];
    assign quo_next  = {quo_q[30:0], fits};

    // Results reflect the step taken this cycle so the caller can commit on the last edge.
    always_comb begin
        quotient  = neg_quo_q ? (-quo_next) : quo_next;
        remainder = neg_rem_q ? (-rem_next) : rem_next;
        if (zero_q) begin
            quotient  = 32'hFFFF_FFFF;
            remainder = dividend_q;
        end else if (early_q) begin
            quotient  = 32'd0;
            remainder = dividend_q;
        end
    end

    always_comb begin
        rem_d      = rem_q;
        quo_d      = quo_q;
        dsor_d     = dsor_q;
        dividend_d = dividend_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        zero_d     = zero_q;
        early_d    = early_q;
        if (load) begin
            rem_d      = 32'd0;
            quo_d      = mag_dividend;
            dsor_d     = mag_divisor;
            dividend_d = dividend;
            neg_quo_d  = is_signed && (dividend[31] ^ divisor[31]);
            neg_rem_d  = is_signed && dividend[31];
            zero_d     = (divisor == 32'd0);
            early_d    = early;
        end else if (step) begin
            rem_d = rem_next;
            quo_d = quo_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            dsor_q     <= 32'd0;
            dividend_q <= 32'd0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            early_q    <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dsor_q     <= dsor_d;
            dividend_q <= dividend_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            zero_q     <= zero_d;
            early_q    <= early_d;
        end
    end

endmodule

// File: rtl/multiply_divide_unit.sv
// rtl/multiply_divide_unit.sv - multi-cycle MDU owning HI/LO (macro MDU_DIV_EARLY_OUT_EN)
module multiply_divide_unit
    import multiply_divide_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mduOp,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic [31:0] mduResult,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    vec64_t           product_q, product_d;
    vec32_t           hi_q, hi_d;
    vec32_t           lo_q, lo_d;

    mdu_op_t            op;
    logic               accept;
    logic               div_load;
    logic               div_step;
    logic               div_signed;
    logic               div_early;
    vec32_t             div_quotient;
    vec32_t             div_remainder;
    logic signed [63:0] product_signed;
    vec64_t             product_unsigned;

    assign op     = mdu_op_t'(mduOp);
    assign busy   = (state_q != IDLE);
    assign stall  = start && (op != mduOp_none) && busy;
    assign accept = start && !busy && (op != mduOp_none);
    assign hi     = hi_q;
    assign lo     = lo_q;

    assign product_signed   = $signed({{32{operand1[31]}}, operand1}) *
                              $signed({{32{operand2[31]}}, operand2});
    assign product_unsigned = {32'd0, operand1} * {32'd0, operand2};

    assign div_load   = accept && ((op == mduOp_div) || (op == mduOp_divu));
    assign div_step   = (state_q == DIV);
    assign div_signed = (op == mduOp_div);

    always_comb begin
        mduResult = 32'd0;
        if (!busy && (op == mduOp_mfhi)) mduResult = hi_q;
        if (!busy && (op == mduOp_mflo)) mduResult = lo_q;
    end

    mdu_divider u_divider (
        .clock     (clock),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .is_signed (div_signed),
        .dividend  (operand1),
        .divisor   (operand2),
        .early     (div_early),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        product_d = product_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        mduOp_mult: begin
                            product_d = product_signed;
                            counter_d = MUL_LOAD;
                            state_d   = MUL;
                        end
                        mduOp_multu: begin
                            product_d = product_unsigned;
                            counter_d = MUL_LOAD;
                            state_d   = MUL;
                        end
                        mduOp_div, mduOp_divu: begin
                            counter_d = div_early ? '0 : DIV_LOAD;
                            state_d   = DIV;
                        end
                        mduOp_mthi: hi_d = operand1;
                        mduOp_mtlo: lo_d = operand1;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (counter_q == '0) begin
                    {hi_d, lo_d} = product_q;
                    state_d      = IDLE;
                end else begin
                    counter_d = counter_q - 1'b1;
                end
            end
            DIV: begin
                // The final step's result comes straight from the divider's combinational output.
                if (counter_q == '0) begin
                    hi_d    = div_remainder;
                    lo_d    = div_quotient;
                    state_d = IDLE;
                end else begin
                    counter_d = counter_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            product_q <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            product_q <= product_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_multiply_divide_unit.sv
// tb/tb_multiply_divide_unit.sv - self-checking bench for multiply_divide_unit (macro MDU_DIV_EARLY_OUT_EN)
module tb_multiply_divide_unit;
    import multiply_divide_unit_pkg::*;

`ifdef MDU_DIV_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mduOp = 4'd0;
    logic [31:0] operand1 = 32'd0;
    logic [31:0] operand2 = 32'd0;
    logic [31:0] mduResult;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    multiply_divide_unit #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .mduOp     (mduOp),
        .operand1  (operand1),
        .operand2  (operand2),
        .mduResult (mduResult),
        .stall     (stall),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        bit          short_div;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start    = 1'b1;
        mduOp    = 4'(o);
        operand1 = a;
        operand2 = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        mduOp = 4'(mduOp_none);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int cyc;
        int exp_cyc;
        int n;

        vecs[0]  = '{mduOp_multu, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE, 1'b0};
        vecs[1]  = '{mduOp_mult,  32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{mduOp_div,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{mduOp_divu,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[4]  = '{mduOp_div,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
        vecs[5]  = '{mduOp_divu,  32'd3,         32'd10,        32'd3,         32'd0,         1'b1};
        vecs[6]  = '{mduOp_div,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[7]  = '{mduOp_mult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
        vecs[8]  = '{mduOp_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,         1'b0};
        vecs[9]  = '{mduOp_div,   32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{mduOp_div,   32'hFFFF_FFFB, 32'd10,        32'hFFFF_FFFB, 32'd0,         1'b1};

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset_busy",  64'(busy),  64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_hi",    64'(hi),    64'd0);
        chk("reset_lo",    64'(lo),    64'd0);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle(cyc);
            if (vecs[i].op == mduOp_mult || vecs[i].op == mduOp_multu)
                exp_cyc = 4;
            else
                exp_cyc = (EARLY_EN && vecs[i].short_div) ? 1 : 32;
            chk($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(exp_cyc));
            chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
        end

        // mflo one cycle behind a multiply: stalled until the product lands
        issue(mduOp_mult, 32'd6, 32'd7);
        start = 1'b1;
        mduOp = 4'(mduOp_mflo);
        #1;
        n = 0;
        while (stall && n < 50) begin
            n++;
            @(posedge clock);
            #2;
        end
        chk("mflo_stall_cycles", 64'(n), 64'd4);
        chk("mflo_busy_after",   64'(busy), 64'd0);
        chk("mflo_result",       64'(mduResult), 64'd42);
        @(negedge clock);
        start = 1'b0;
        mduOp = 4'(mduOp_none);

        issue(mduOp_mthi, 32'd5, 32'd0);
        chk("mthi_hi",   64'(hi),   64'd5);
        chk("mthi_busy", 64'(busy), 64'd0);
        issue(mduOp_mtlo, 32'h1234_5678, 32'd0);
        chk("mtlo_lo", 64'(lo), 64'h1234_5678);

        @(negedge clock);
        start = 1'b1;
        mduOp = 4'(mduOp_mfhi);
        #1;
        chk("mfhi_result", 64'(mduResult), 64'd5);
        chk("mfhi_stall",  64'(stall),     64'd0);
        @(posedge clock);
        #1;
        chk("mfhi_no_busy", 64'(busy), 64'd0);
        start = 1'b0;
        mduOp = 4'(mduOp_none);

        issue(mduOp_divu, 32'd1000, 32'd7);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi",   64'(hi),   64'd0);
        chk("abort_lo",   64'(lo),   64'd0);
        @(negedge clock);
        reset = 1'b0;

        issue(mduOp_divu, 32'd100, 32'd7);
        wait_idle(cyc);
        chk("post_reset_div_cycles", 64'(cyc), 64'd32);
        chk("post_reset_div_hi",     64'(hi),  64'd2);
        chk("post_reset_div_lo",     64'(lo),  64'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
